// File: rtl/ldst_ctrl_pkg.sv
// ldst_ctrl_pkg: shared widths, store latency and FSM state encoding for the load/store controller
package ldst_ctrl_pkg;
    localparam int DWIDTH     = 32;
    localparam int BUF_AWIDTH = 10;
    localparam int CNT_WIDTH  = 16;
    localparam int STORE_LAT  = 4;
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] DRAIN = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;
endpackage

// File: rtl/ldst_ctrl_if.sv
// ldst_ctrl_if: run control, buffer and PE data signals of the load/store controller
interface ldst_ctrl_if #(
    parameter int DWIDTH     = ldst_ctrl_pkg::DWIDTH,
    parameter int BUF_AWIDTH = ldst_ctrl_pkg::BUF_AWIDTH,
    parameter int CNT_WIDTH  = ldst_ctrl_pkg::CNT_WIDTH
);
    logic                  Start;
    logic [CNT_WIDTH-1:0]  Run_Len;
    logic                  PE_Array_Busy;
    logic                  Done;
    logic                  In_Buf_Rd_En;
    logic [BUF_AWIDTH-1:0] In_Buf_Addr;
    logic [DWIDTH-1:0]     In_Buf_Dout;
    logic [DWIDTH-1:0]     PE_Load;
    logic [DWIDTH-1:0]     PE_Store;
    logic                  Out_Buf_Wr_En;
    logic [BUF_AWIDTH-1:0] Out_Buf_Addr;
    logic [DWIDTH-1:0]     Out_Buf_Din;
    modport master (
        input  Start, Run_Len, In_Buf_Dout, PE_Store,
        output PE_Array_Busy, Done, In_Buf_Rd_En, In_Buf_Addr, PE_Load,
               Out_Buf_Wr_En, Out_Buf_Addr, Out_Buf_Din
    );
    modport slave (
        output Start, Run_Len, In_Buf_Dout, PE_Store,
        input  PE_Array_Busy, Done, In_Buf_Rd_En, In_Buf_Addr, PE_Load,
               Out_Buf_Wr_En, Out_Buf_Addr, Out_Buf_Din
    );
endinterface

// File: rtl/ldst_ctrl_delay_line.sv
// delay_line: 1-bit shift register delaying d by DEPTH clock cycles
module delay_line #(
    parameter int DEPTH = 4
) (
    input  logic Clk,
    input  logic Resetn,
    input  logic d,
    output logic q
);
    logic [DEPTH-1:0] sr;
    always_ff @(posedge Clk or negedge Resetn)
        if (!Resetn) sr <= '0;
        else sr <= DEPTH'({sr, d});
    assign q = sr[DEPTH-1];
endmodule

// File: rtl/ldst_ctrl.sv
// ldst_ctrl: streams Run_Len words from the input buffer to the PE and PE results back to the output buffer
import ldst_ctrl_pkg::*;
module ldst_ctrl #(
    parameter int DWIDTH     = ldst_ctrl_pkg::DWIDTH,
    parameter int BUF_AWIDTH = ldst_ctrl_pkg::BUF_AWIDTH,
    parameter int CNT_WIDTH  = ldst_ctrl_pkg::CNT_WIDTH,
    parameter int STORE_LAT  = ldst_ctrl_pkg::STORE_LAT
) (
    input logic         Clk,
    input logic         Resetn,
    ldst_ctrl_if.master bus
);
    logic [1:0]           state, nxt;
    logic [CNT_WIDTH-1:0] len, rd_cnt, wr_cnt;
    logic [DWIDTH-1:0]    load_q;
    logic                 busy, rd_vld, done, wr_en;
    // zero-length runs pass through DRAIN so Done lands two cycles after Start
    always_comb
        nxt = state == IDLE  ? (bus.Start ? (|bus.Run_Len ? RUN : DRAIN) : IDLE) :
              state == RUN   ? (rd_cnt == len - CNT_WIDTH'(1) ? DRAIN : RUN) :
              state == DRAIN ? (wr_cnt + CNT_WIDTH'(wr_en) == len ? DONE : DRAIN) : IDLE;
    always_ff @(posedge Clk or negedge Resetn)
        if (!Resetn) begin
            state  <= IDLE;
            len    <= '0;
            rd_cnt <= '0;
            wr_cnt <= '0;
            load_q <= '0;
            busy   <= 1'b0;
            rd_vld <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= nxt;
            busy   <= nxt == RUN;
            done   <= nxt == DONE;
            rd_vld <= busy;
            if (rd_vld) load_q <= bus.In_Buf_Dout;
            if (state == IDLE && bus.Start) begin
                len    <= bus.Run_Len;
                rd_cnt <= '0;
                wr_cnt <= '0;
            end else begin
                if (state == RUN) rd_cnt <= rd_cnt + CNT_WIDTH'(1);
                if (wr_en) wr_cnt <= wr_cnt + CNT_WIDTH'(1);
            end
        end
    delay_line #(.DEPTH(STORE_LAT)) u_store_vld (.Clk(Clk), .Resetn(Resetn), .d(busy), .q(wr_en));
    assign bus.PE_Array_Busy = busy;
    assign bus.In_Buf_Rd_En  = busy;
    assign bus.In_Buf_Addr   = rd_cnt[BUF_AWIDTH-1:0];
    assign bus.PE_Load       = load_q;
    assign bus.Done          = done;
    assign bus.Out_Buf_Wr_En = wr_en;
    assign bus.Out_Buf_Addr  = wr_cnt[BUF_AWIDTH-1:0];
    assign bus.Out_Buf_Din   = bus.PE_Store;
endmodule

// File: tb/tb_ldst_ctrl.sv
// tb_ldst_ctrl: randomized runs of ldst_ctrl checked cycle by cycle against a timing-rule reference model
module tb_ldst_ctrl;
    localparam int L = 4;
    logic Clk = 1'b0;
    logic Resetn = 1'b0;
    int checks = 0;
    int errors = 0;
    logic [31:0] in_mem [1024];
    logic [31:0] exp_load;
    ldst_ctrl_if #(.DWIDTH(32), .BUF_AWIDTH(10), .CNT_WIDTH(16)) bus ();
    ldst_ctrl dut (.Clk(Clk), .Resetn(Resetn), .bus(bus));
    always #5 Clk = ~Clk;
    always @(posedge Clk)
        if (bus.In_Buf_Rd_En) bus.In_Buf_Dout <= in_mem[bus.In_Buf_Addr];
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", tag, obs, exp, $time);
        end
    endtask
    task automatic chk_idle_outputs(input string tag);
        chk({tag, "_busy"}, bus.PE_Array_Busy, 0);
        chk({tag, "_rd_en"}, bus.In_Buf_Rd_En, 0);
        chk({tag, "_wr_en"}, bus.Out_Buf_Wr_En, 0);
        chk({tag, "_done"}, bus.Done, 0);
    endtask
    // relative index r: negedge following the Start-sampling edge is r=0
    task automatic run(input int n, input bit noise);
        int last, wrs, dones;
        bit exp_busy, exp_wr;
        last = n == 0 ? 1 : n + L;
        wrs = 0;
        dones = 0;
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Run_Len = 16'(n);
        bus.PE_Store = $urandom;
        for (int r = 0; r <= last; r++) begin
            @(negedge Clk);
            exp_busy = r < n;
            exp_wr = r >= L && r < n + L;
            if (r >= 2 && r < n + 2) exp_load = in_mem[(r - 2) % 1024];
            chk("busy", bus.PE_Array_Busy, exp_busy);
            chk("rd_en", bus.In_Buf_Rd_En, exp_busy);
            if (exp_busy) chk("rd_addr", bus.In_Buf_Addr, r % 1024);
            chk("wr_en", bus.Out_Buf_Wr_En, exp_wr);
            if (exp_wr) begin
                chk("wr_addr", bus.Out_Buf_Addr, (r - L) % 1024);
                chk("wr_data", bus.Out_Buf_Din, bus.PE_Store);
            end
            chk("done", bus.Done, r == last);
            chk("pe_load", bus.PE_Load, exp_load);
            wrs += int'(bus.Out_Buf_Wr_En);
            dones += int'(bus.Done);
            bus.Start = noise && r < last && $urandom_range(0, 2) == 0;
            bus.Run_Len = noise ? 16'($urandom_range(0, 60)) : 16'(n);
            bus.PE_Store = $urandom;
        end
        chk("wr_count", wrs, n);
        chk("done_count", dones, 1);
    endtask
    initial begin
        #1_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        bus.Start = 1'b0;
        bus.Run_Len = '0;
        bus.PE_Store = '0;
        exp_load = '0;
        for (int i = 0; i < 1024; i++) in_mem[i] = 32'h100 + i;
        #1;
        chk_idle_outputs("rst");
        chk("rst_rd_addr", bus.In_Buf_Addr, 0);
        chk("rst_wr_addr", bus.Out_Buf_Addr, 0);
        chk("rst_load", bus.PE_Load, 0);
        repeat (2) @(negedge Clk);
        Resetn = 1'b1;
        run(5, 0);
        run(0, 0);
        run(1030, 0);
        for (int i = 0; i < 1024; i++) in_mem[i] = $urandom;
        run(7, 1);
        run(7, 0);
        for (int t = 0; t < 6; t++) run($urandom_range(0, 40), 1);
        @(negedge Clk);
        bus.Start = 1'b1;
        bus.Run_Len = 16'd8;
        @(negedge Clk);
        bus.Start = 1'b0;
        repeat (2) @(negedge Clk);
        chk("pre_abort_busy", bus.PE_Array_Busy, 1);
        #2 Resetn = 1'b0;
        #1;
        exp_load = '0;
        chk_idle_outputs("abort");
        chk("abort_rd_addr", bus.In_Buf_Addr, 0);
        chk("abort_wr_addr", bus.Out_Buf_Addr, 0);
        chk("abort_load", bus.PE_Load, 0);
        repeat (2) @(negedge Clk);
        Resetn = 1'b1;
        repeat (20) begin
            @(negedge Clk);
            chk_idle_outputs("post_abort");
        end
        run(5, 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
